instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Responder (memory side) of the instruction-fetch req/gnt/rvalid protocol; answers the fetch initiator in the IF stage.
- Word-organised instruction memory with configurable grant delay, fixed read latency, bounded outstanding requests and error signalling.
- Includes a preload port so the bench or boot logic can fill memory before fetch begins.

Parameters:
- MemWords, 1024, memory depth in 32-bit words.
- BaseAddr, 32'h0000_0000, byte address of word 0.
- GntDelay, 0, cycles req must be held before gnt can assert (0..15).
- RvalidLatency, 1, cycles from grant handshake to rvalid (1..8).
- MaxOutstanding, 2, maximum granted-but-unanswered requests (1..RvalidLatency+1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- instr_req_i  in  1  request from initiator; held with addr until gnt.
- instr_addr_i  in  32  byte address of fetch.
- instr_gnt_o  out  1  grant; handshake = req & gnt in same cycle.
- instr_rvalid_o  out  1  one-cycle response strobe.
- instr_rdata_o  out  32  read data, valid with rvalid.
- instr_err_o  out  1  error flag, valid with rvalid.
- load_we_i  in  1  preload write enable.
- load_addr_i  in  32  preload byte address.
- load_data_i  in  32  preload word.

Behaviour:
- One clock; reset is synchronous and active-low: clk_i, rst_ni.
- Reset: gnt=0, rvalid=0, rdata=0, err=0; wait counter, outstanding count and response pipeline cleared. Memory contents not reset.
- Address decode: ok = addr[1:0]==0 and BaseAddr <= addr < BaseAddr+4*MemWords; index = (addr-BaseAddr)>>2.
- Wait counter: increments each cycle req=1 and no handshake, saturates at GntDelay. Clears on handshake or req=0.
- gnt (combinational from state/inputs) = rst_ni & req & (wait_cnt==GntDelay) & (outstanding<MaxOutstanding) & !load_we_i.
- GntDelay=0 means gnt in the same cycle as req.
- Outstanding limit uses the registered count. A slot freed by an rvalid in cycle N is first usable in cycle N+1.
- On handshake in cycle N, the entry enters the delay line: data = ok ? mem[index] : 0, err = !ok. Data is snapshot at N.
- Delay line depth RvalidLatency, no backpressure. The entry emerges as rvalid=1 in cycle N+RvalidLatency with its rdata/err.
- Responses are strictly in grant order, one per handshake.
- rdata=0 and err=0 whenever rvalid=0.
- Outstanding count: +1 on handshake, -1 on rvalid; both in the same cycle gives net 0. Never exceeds MaxOutstanding.
- Preload: load_we_i=1 with ok address writes mem[index] at the clock edge. Misaligned or out-of-range loads are silently dropped.
- Load has priority over grant. In-flight reads already have their snapshot and are unaffected.
- Address change while req=1 and not granted: the initiator must not do this. If it does, the address sampled at the handshake wins.
- Reset mid-operation: all in-flight responses discarded, no rvalid after reset release until a new handshake.

Test Plan:
- Preload 0x10=0xDEADBEEF; GntDelay=0, RvalidLatency=1; req addr 0x10 at cycle 0 -> gnt cycle 0; rvalid=1, rdata=0xDEADBEEF, err=0 at cycle 1.
- GntDelay=2; req held with addr 0x0 from cycle 0 -> gnt=0 cycles 0-1, gnt=1 cycle 2; rvalid cycle 3.
- req addr 0x12 (misaligned), then addr 0x1000 (MemWords=1024, out of range) -> each granted; rvalid with err=1, rdata=0.
- MaxOutstanding=2, RvalidLatency=3, req held continuously from cycle 0 -> gnt cycles 0,1; blocked cycles 2,3; rvalid cycles 3,4; next gnt cycle 4; data returned in order.
- load_we_i=1 to 0x20 and req addr 0x20 in cycle 0 -> no gnt cycle 0, write done; gnt cycle 1; rvalid cycle 2 returns the new word.
- Handshake at cycle 0 with RvalidLatency=3; rst_ni=0 in cycle 1 -> no rvalid in cycles 2-5; outputs all zero; next request after release behaves as in scenario 1.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Memory-side responder for the instruction-fetch req/gnt/rvalid protocol: word memory with
// grant delay, fixed-latency in-order responses, an outstanding-request cap and a preload port.
module instr_mem_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned GntDelay       = 0,
  parameter int unsigned RvalidLatency  = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i
);

  localparam int unsigned IdxW      = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam logic [32:0] SpanBytes = 33'(MemWords) * 33'd4;

  logic [31:0]              mem [MemWords];
  logic [3:0]               wait_cnt;
  logic [3:0]               outstanding;
  logic [RvalidLatency-1:0] pipe_vld;
  logic [RvalidLatency-1:0] pipe_err;
  logic [31:0]              pipe_dat [RvalidLatency];

  logic            req_ok;
  logic            load_ok;
  logic [IdxW-1:0] req_idx;
  logic [IdxW-1:0] load_idx;
  logic            handshake;
  logic            rsp_out;

  // 33-bit offset so addresses below BaseAddr show up as a borrow rather than wrapping.
  function automatic logic addr_ok(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BaseAddr};
    return (a[1:0] == 2'b00) && !off[32] && (off < SpanBytes);
  endfunction

  function automatic logic [IdxW-1:0] addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BaseAddr;
    return IdxW'(off >> 2);
  endfunction

  always_comb begin
    req_ok    = addr_ok(instr_addr_i);
    req_idx   = addr_idx(instr_addr_i);
    load_ok   = addr_ok(load_addr_i);
    load_idx  = addr_idx(load_addr_i);
    instr_gnt_o = rst_ni && instr_req_i && (wait_cnt == 4'(GntDelay)) &&
                  (outstanding < 4'(MaxOutstanding)) && !load_we_i;
    handshake = instr_req_i && instr_gnt_o;
    rsp_out   = pipe_vld[RvalidLatency-1];
  end

  always_ff @(posedge clk_i) begin
    if (load_we_i && load_ok) begin
      mem[load_idx] <= load_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt <= 4'd0;
    end else if (!instr_req_i || handshake) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != 4'(GntDelay)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outstanding <= 4'd0;
    end else begin
      case ({handshake, rsp_out})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Idle stages carry zero data, so the output stage needs no masking when rvalid is low.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      for (int i = 0; i < RvalidLatency; i++) begin
        pipe_dat[i] <= 32'd0;
      end
    end else begin
      pipe_vld[0] <= handshake;
      pipe_err[0] <= handshake && !req_ok;
      pipe_dat[0] <= (handshake && req_ok) ? mem[req_idx] : 32'd0;
      for (int i = 1; i < RvalidLatency; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_err[i] <= pipe_err[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign instr_rvalid_o = rsp_out;
  assign instr_rdata_o  = pipe_dat[RvalidLatency-1];
  assign instr_err_o    = pipe_err[RvalidLatency-1];

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: directed scenarios on three configurations plus a randomized
// run checked against a queue-based reference model.
module tb_instr_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // A: GntDelay 0, latency 1.  B: GntDelay 2, latency 1.  C: GntDelay 0, latency 3.
  logic a_rst = 0, a_req = 0, a_we = 0, a_gnt, a_rv, a_err;
  logic [31:0] a_addr = 0, a_laddr = 0, a_ldata = 0, a_rd;
  logic b_rst = 0, b_req = 0, b_we = 0, b_gnt, b_rv, b_err;
  logic [31:0] b_addr = 0, b_laddr = 0, b_ldata = 0, b_rd;
  logic c_rst = 0, c_req = 0, c_we = 0, c_gnt, c_rv, c_err;
  logic [31:0] c_addr = 0, c_laddr = 0, c_ldata = 0, c_rd;

  instr_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .GntDelay(0), .RvalidLatency(1),
                        .MaxOutstanding(2)) u_a (
    .clk_i(clk), .rst_ni(a_rst), .instr_req_i(a_req), .instr_addr_i(a_addr),
    .instr_gnt_o(a_gnt), .instr_rvalid_o(a_rv), .instr_rdata_o(a_rd), .instr_err_o(a_err),
    .load_we_i(a_we), .load_addr_i(a_laddr), .load_data_i(a_ldata));

  instr_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .GntDelay(2), .RvalidLatency(1),
                        .MaxOutstanding(2)) u_b (
    .clk_i(clk), .rst_ni(b_rst), .instr_req_i(b_req), .instr_addr_i(b_addr),
    .instr_gnt_o(b_gnt), .instr_rvalid_o(b_rv), .instr_rdata_o(b_rd), .instr_err_o(b_err),
    .load_we_i(b_we), .load_addr_i(b_laddr), .load_data_i(b_ldata));

  instr_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .GntDelay(0), .RvalidLatency(3),
                        .MaxOutstanding(2)) u_c (
    .clk_i(clk), .rst_ni(c_rst), .instr_req_i(c_req), .instr_addr_i(c_addr),
    .instr_gnt_o(c_gnt), .instr_rvalid_o(c_rv), .instr_rdata_o(c_rd), .instr_err_o(c_err),
    .load_we_i(c_we), .load_addr_i(c_laddr), .load_data_i(c_ldata));

  // Tasks start and end just after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic load_a(input logic [31:0] addr, input logic [31:0] data);
    a_we = 1; a_laddr = addr; a_ldata = data; next_cyc(); a_we = 0;
  endtask

  task automatic load_b(input logic [31:0] addr, input logic [31:0] data);
    b_we = 1; b_laddr = addr; b_ldata = data; next_cyc(); b_we = 0;
  endtask

  task automatic load_c(input logic [31:0] addr, input logic [31:0] data);
    c_we = 1; c_laddr = addr; c_ldata = data; next_cyc(); c_we = 0;
  endtask

  task automatic test_reset();
    a_rst = 0; b_rst = 0; c_rst = 0;
    a_req = 1; a_addr = 32'h0;
    next_cyc(); next_cyc();
    sample();
    checks++;
    if ({a_gnt, a_rv, a_err, a_rd} !== 35'd0) begin
      errors++;
      $display("FAIL reset_a: gnt=%0b rv=%0b err=%0b rdata=%h, want all zero", a_gnt, a_rv, a_err, a_rd);
    end
    checks++;
    if ({b_gnt, b_rv, b_err, b_rd} !== 35'd0) begin
      errors++;
      $display("FAIL reset_b: gnt=%0b rv=%0b err=%0b rdata=%h, want all zero", b_gnt, b_rv, b_err, b_rd);
    end
    checks++;
    if ({c_gnt, c_rv, c_err, c_rd} !== 35'd0) begin
      errors++;
      $display("FAIL reset_c: gnt=%0b rv=%0b err=%0b rdata=%h, want all zero", c_gnt, c_rv, c_err, c_rd);
    end
    next_cyc();
    a_req = 0; a_rst = 1; b_rst = 1; c_rst = 1;
    next_cyc();
    sample();
    checks++;
    if ({a_rv, c_rv} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_rv: a_rv=%0b c_rv=%0b, want 0 0", a_rv, c_rv);
    end
    next_cyc();
  endtask

  task automatic test_basic_read();
    load_a(32'h10, 32'hDEAD_BEEF);
    a_req = 1; a_addr = 32'h10;
    sample();
    checks++;
    if (a_gnt !== 1'b1) begin
      errors++;
      $display("FAIL basic_gnt: gnt=%0b, want 1", a_gnt);
    end
    next_cyc();
    a_req = 0;
    sample();
    checks++;
    if ({a_rv, a_err, a_rd} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL basic_rsp: rv=%0b err=%0b rdata=%h, want 1 0 deadbeef", a_rv, a_err, a_rd);
    end
    next_cyc();
    sample();
    checks++;
    if ({a_rv, a_err, a_rd} !== 34'd0) begin
      errors++;
      $display("FAIL basic_idle: rv=%0b err=%0b rdata=%h, want all zero", a_rv, a_err, a_rd);
    end
    next_cyc();
  endtask

  task automatic test_errors();
    logic [31:0] bad [4];
    bad = '{32'h12, 32'h1000, 32'hFFFF_FFFC, 32'h3};
    for (int i = 0; i < 4; i++) begin
      a_req = 1; a_addr = bad[i];
      sample();
      checks++;
      if (a_gnt !== 1'b1) begin
        errors++;
        $display("FAIL err_gnt[%0h]: gnt=%0b, want 1", bad[i], a_gnt);
      end
      next_cyc();
      a_req = 0;
      sample();
      checks++;
      if ({a_rv, a_err, a_rd} !== {1'b1, 1'b1, 32'd0}) begin
        errors++;
        $display("FAIL err_rsp[%0h]: rv=%0b err=%0b rdata=%h, want 1 1 0", bad[i], a_rv, a_err, a_rd);
      end
      next_cyc();
    end
  endtask

  task automatic test_load_priority();
    load_a(32'h20, 32'h1111_1111);
    a_we = 1; a_laddr = 32'h20; a_ldata = 32'hCAFE_F00D;
    a_req = 1; a_addr = 32'h20;
    sample();
    checks++;
    if (a_gnt !== 1'b0) begin
      errors++;
      $display("FAIL load_blocks_gnt: gnt=%0b, want 0", a_gnt);
    end
    next_cyc();
    a_we = 0;
    sample();
    checks++;
    if (a_gnt !== 1'b1) begin
      errors++;
      $display("FAIL load_then_gnt: gnt=%0b, want 1", a_gnt);
    end
    next_cyc();
    a_req = 0;
    sample();
    checks++;
    if ({a_rv, a_err, a_rd} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL load_new_word: rv=%0b err=%0b rdata=%h, want 1 0 cafef00d", a_rv, a_err, a_rd);
    end
    next_cyc();
    // Bad loads that would alias word 8 if the decode were sloppy must be dropped.
    load_a(32'h22, 32'h0BAD_0001);
    load_a(32'h1020, 32'h0BAD_0002);
    a_req = 1; a_addr = 32'h20;
    next_cyc();
    a_req = 0;
    sample();
    checks++;
    if ({a_rv, a_err, a_rd} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL bad_load_dropped: rv=%0b err=%0b rdata=%h, want 1 0 cafef00d", a_rv, a_err, a_rd);
    end
    next_cyc();
  endtask

  task automatic test_gnt_delay();
    logic exp_g, exp_rv;
    load_b(32'h0, 32'h1234_5678);
    for (int k = 0; k < 5; k++) begin
      b_req = (k <= 2); b_addr = 32'h0;
      sample();
      exp_g  = (k == 2);
      exp_rv = (k == 3);
      checks++;
      if (b_gnt !== exp_g) begin
        errors++;
        $display("FAIL delay_gnt[c%0d]: gnt=%0b, want %0b", k, b_gnt, exp_g);
      end
      checks++;
      if ({b_rv, b_err, b_rd} !== (exp_rv ? {1'b1, 1'b0, 32'h1234_5678} : 34'd0)) begin
        errors++;
        $display("FAIL delay_rsp[c%0d]: rv=%0b err=%0b rdata=%h, want rv=%0b", k, b_rv, b_err, b_rd, exp_rv);
      end
      next_cyc();
    end
  endtask

  task automatic test_outstanding();
    logic [9:0] g_tbl;
    logic [9:0] rv_tbl;
    int ng;
    int nr;
    g_tbl  = 10'b00_0011_0011;
    rv_tbl = 10'b01_1001_1000;
    ng = 0; nr = 0;
    for (int i = 0; i < 4; i++) load_c(32'h40 + 32'(4 * i), 32'h0B00_0000 + 32'(i));
    for (int k = 0; k < 10; k++) begin
      c_req = (k < 8); c_addr = 32'h40 + 32'(4 * ng);
      sample();
      checks++;
      if (c_gnt !== g_tbl[k]) begin
        errors++;
        $display("FAIL outst_gnt[c%0d]: gnt=%0b, want %0b", k, c_gnt, g_tbl[k]);
      end
      checks++;
      if ({c_rv, c_err, c_rd} !== (rv_tbl[k] ? {1'b1, 1'b0, 32'h0B00_0000 + 32'(nr)} : 34'd0)) begin
        errors++;
        $display("FAIL outst_rsp[c%0d]: rv=%0b err=%0b rdata=%h, want rv=%0b rdata=%h",
                 k, c_rv, c_err, c_rd, rv_tbl[k], 32'h0B00_0000 + 32'(nr));
      end
      if (g_tbl[k]) ng++;
      if (rv_tbl[k]) nr++;
      next_cyc();
    end
  endtask

  task automatic test_reset_mid();
    logic [33:0] exp;
    load_c(32'h50, 32'hA5A5_A5A5);
    load_c(32'h54, 32'h5A5A_5A5A);
    c_req = 1; c_addr = 32'h50;
    sample();
    checks++;
    if (c_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_gnt: gnt=%0b, want 1", c_gnt);
    end
    next_cyc();
    c_req = 0; c_rst = 0;
    next_cyc();
    c_rst = 1;
    for (int k = 2; k <= 5; k++) begin
      sample();
      checks++;
      if ({c_gnt, c_rv, c_err, c_rd} !== 35'd0) begin
        errors++;
        $display("FAIL rstmid_quiet[c%0d]: gnt=%0b rv=%0b err=%0b rdata=%h, want all zero",
                 k, c_gnt, c_rv, c_err, c_rd);
      end
      next_cyc();
    end
    // Two back-to-back grants show the outstanding count really was cleared.
    for (int j = 0; j < 6; j++) begin
      c_req = (j < 2); c_addr = 32'h50 + 32'(4 * j);
      sample();
      checks++;
      if (c_gnt !== (j < 2)) begin
        errors++;
        $display("FAIL rstmid_regnt[%0d]: gnt=%0b, want %0b", j, c_gnt, (j < 2));
      end
      exp = (j == 3) ? {1'b1, 1'b0, 32'hA5A5_A5A5} :
            (j == 4) ? {1'b1, 1'b0, 32'h5A5A_5A5A} : 34'd0;
      checks++;
      if ({c_rv, c_err, c_rd} !== exp) begin
        errors++;
        $display("FAIL rstmid_rsp[%0d]: rv=%0b err=%0b rdata=%h, want %h", j, c_rv, c_err, c_rd, exp);
      end
      next_cyc();
    end
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return 32'($urandom_range(0, 15)) * 4;
    if (r == 6) return 32'hFFC;
    if (r == 7) return 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
    if (r == 8) return 32'h1000 + 32'($urandom_range(0, 15)) * 4;
    return 32'h8000_0000 | 32'($urandom);
  endfunction

  function automatic logic model_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'h1000);
  endfunction

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } rsp_t;

  task automatic test_random();
    logic [31:0] mm [1024];
    rsp_t        q[$];
    rsp_t        ent;
    logic [33:0] exp_rsp;
    logic        exp_g;
    logic        pending;
    logic [31:0] w;
    int          wait_n;
    int          outst;
    c_rst = 0; c_req = 0; c_we = 0;
    next_cyc();
    c_rst = 1;
    for (int i = 0; i < 17; i++) begin
      w = (i == 16) ? 32'd1023 : 32'(i);
      mm[w] = $urandom;
      load_c(w * 4, mm[w]);
    end
    pending = 0; wait_n = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (!pending) begin
        c_req  = (cyc < 490) && ($urandom_range(0, 3) != 0);
        c_addr = pick_addr();
      end
      c_we    = ($urandom_range(0, 5) == 0);
      c_laddr = pick_addr();
      c_ldata = $urandom;
      sample();
      outst = q.size();
      exp_g = c_req && (wait_n >= 0) && (outst < 2) && !c_we;
      checks++;
      if (c_gnt !== exp_g) begin
        errors++;
        $display("FAIL rand_gnt[c%0d]: gnt=%0b, want %0b (outst=%0d we=%0b)", cyc, c_gnt, exp_g, outst, c_we);
      end
      exp_rsp = 34'd0;
      if (q.size() > 0 && q[0].due == cyc) begin
        ent = q.pop_front();
        exp_rsp = {1'b1, ent.e, ent.d};
      end
      checks++;
      if ({c_rv, c_err, c_rd} !== exp_rsp) begin
        errors++;
        $display("FAIL rand_rsp[c%0d]: rv=%0b err=%0b rdata=%h, want %h", cyc, c_rv, c_err, c_rd, exp_rsp);
      end
      if (exp_g) begin
        ent.due = cyc + 3;
        ent.e   = !model_ok(c_addr);
        ent.d   = model_ok(c_addr) ? mm[c_addr / 4] : 32'd0;
        q.push_back(ent);
      end
      wait_n  = (c_req && !exp_g) ? wait_n + 1 : 0;
      pending = c_req && !exp_g;
      if (c_we && model_ok(c_laddr)) mm[c_laddr / 4] = c_ldata;
      next_cyc();
    end
    c_req = 0; c_we = 0;
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_errors();
    test_load_priority();
    test_gnt_delay();
    test_outstanding();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
